rom_scanner: RTL and testbench

ROM_SCANNER -- requirements
Module: rom_scanner

---
 rtl/rom_scanner.sv | 119 +++++++++++
 tb/tb_rom_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_scanner.sv
// Strided ROM reader: walks len words from base in increments of step and
// streams them out through a one-entry registered output slot.
module rom_scanner #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                slot_free;

  // Output handshake: a word moves when out_valid & out_ready are both high
  // in the same cycle; once raised, out_valid stays high with out_data stable
  // until that transfer happens (abort and reset are the only exceptions).
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE does nothing itself but masks a coincident start
        if (start && !abort) begin
          step_d      = step;
          rom_addr_d  = base;
          remaining_d = len;
          state_d     = (len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (slot_free) begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          rom_addr_d  = rom_addr_q + step_q;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rom_scanner.sv
// Directed bench for rom_scanner: cycle-by-cycle vector table, transfer
// scoreboard, and a hand-written asynchronous reset sequence.
module tb_rom_scanner;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base;
  logic [7:0] step;
  logic [7:0] len;
  logic       abort;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       start;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] len;
    logic       ready;
    logic       abort;
    logic       e_valid;
    logic [3:0] e_data;
    logic [7:0] e_addr;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  rom_scanner #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .step      (step),
    .len       (len),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ROM contents: addr n -> 2n for n < 8, else 0
  always_comb rom_data = (rom_addr < 8'd8) ? {rom_addr[2:0], 1'b0} : 4'd0;

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- driver / checker tasks ----
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [7:0] b, input logic [7:0] s,
                              input logic [7:0] l, input logic rdy, input logic ab,
                              input logic ev, input logic [3:0] ed, input logic [7:0] ea,
                              input logic eb, input logic edn);
    vec_t v;
    v.start = st;  v.base = b;  v.step = s;  v.len = l;
    v.ready = rdy; v.abort = ab;
    v.e_valid = ev; v.e_data = ed; v.e_addr = ea; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  // Called just after a falling edge: drive, check pre-edge outputs, advance one cycle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] e;
    start = v.start; base = v.base; step = v.step; len = v.len;
    out_ready = v.ready; abort = v.abort;
    #1;
    chk($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(v.e_valid));
    chk($sformatf("row%0d out_data", idx),  32'(out_data),  32'(v.e_data));
    chk($sformatf("row%0d rom_addr", idx),  32'(rom_addr),  32'(v.e_addr));
    chk($sformatf("row%0d busy", idx),      32'(busy),      32'(v.e_busy));
    chk($sformatf("row%0d done", idx),      32'(done),      32'(v.e_done));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("row%0d unexpected transfer", idx), 32'(out_data), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("row%0d transfer word", idx), 32'(out_data), 32'(e));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; step = '0; len = '0;
    abort = 1'b0; out_ready = 1'b0;

    // Full 8-word scan, with start pulses while busy and in FIN that must be ignored
    vecs.push_back(mk(1,   0, 1, 8, 1, 0,  0,  0,   0, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  0,   0, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  0,   1, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  2,   2, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  4,   3, 1, 0));
    vecs.push_back(mk(1, 100, 3, 2, 1, 0,  1,  6,   4, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  8,   5, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1, 10,   6, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1, 12,   7, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1, 14,   8, 1, 0));
    vecs.push_back(mk(1, 100, 3, 2, 1, 0,  0, 14,   8, 1, 1));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0, 14,   8, 0, 0));
    // Stride 2 with out_ready toggling
    vecs.push_back(mk(1,   2, 2, 3, 0, 0,  0, 14,   8, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0, 14,   2, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  1,  4,   4, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  4,   4, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  1,  8,   6, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  8,   6, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  1, 12,   8, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1, 12,   8, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  0, 12,   8, 1, 1));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  0, 12,   8, 0, 0));
    // Address wrap 254 -> 1
    vecs.push_back(mk(1, 254, 1, 4, 1, 0,  0, 12,   8, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0, 12, 254, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  0, 255, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  0,   0, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  0,   1, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  2,   2, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  2,   2, 1, 1));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  2,   2, 0, 0));
    // Zero-length scan
    vecs.push_back(mk(1,   9, 1, 0, 1, 0,  0,  2,   2, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  2,   9, 1, 1));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  2,   9, 0, 0));
    // Abort after two transfers, then a fresh one-word scan
    vecs.push_back(mk(1,   0, 1, 8, 1, 0,  0,  2,   9, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  2,   0, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  0,   1, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1,  2,   2, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  1,  4,   3, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 1,  1,  4,   3, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  0,  4,   3, 0, 0));
    vecs.push_back(mk(1,   5, 1, 1, 1, 0,  0,  4,   3, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0,  4,   5, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  1, 10,   6, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0, 10,   6, 1, 1));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0, 10,   6, 0, 0));
    // abort in IDLE masks a coincident start
    vecs.push_back(mk(1,  50, 1, 3, 1, 1,  0, 10,   6, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 1, 0,  0, 10,   6, 0, 0));
    // Scan that will be cut by an asynchronous reset
    vecs.push_back(mk(1,   0, 1, 8, 0, 0,  0, 10,   6, 0, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  0, 10,   0, 1, 0));
    vecs.push_back(mk(0,   0, 0, 0, 0, 0,  1,  0,   1, 1, 0));

    exp_q = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14,
              4'd4, 4'd8, 4'd12,
              4'd0, 4'd0, 4'd0, 4'd2,
              4'd0, 4'd2, 4'd10};

    // Reset state
    #1;
    chk("reset rom_addr",  32'(rom_addr),  0);
    chk("reset out_data",  32'(out_data),  0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset busy",      32'(busy),      0);
    chk("reset done",      32'(done),      0);
    chk("reset state",     32'(state_dbg), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Asynchronous reset mid-scan, between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst rom_addr",  32'(rom_addr),  0);
    chk("async rst out_data",  32'(out_data),  0);
    chk("async rst out_valid", 32'(out_valid), 0);
    chk("async rst busy",      32'(busy),      0);
    chk("async rst done",      32'(done),      0);
    chk("async rst state",     32'(state_dbg), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    exp_q.push_back(4'd6);
    run_vec(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0), 100);
    run_vec(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0), 101);
    run_vec(mk(1, 3, 1, 1, 1, 0,  0, 0, 0, 0, 0), 102);
    run_vec(mk(0, 0, 0, 0, 1, 0,  0, 0, 3, 1, 0), 103);
    run_vec(mk(0, 0, 0, 0, 1, 0,  1, 6, 4, 1, 0), 104);
    run_vec(mk(0, 0, 0, 0, 1, 0,  0, 6, 4, 1, 1), 105);
    run_vec(mk(0, 0, 0, 0, 1, 0,  0, 6, 4, 0, 0), 106);

    chk("scoreboard leftover words", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
